// File: rtl/fetch_stage.sv
// fetch_stage: RV32I IF stage + IF/ID register with a req/gnt/rvalid imem port and a one-entry stall hold buffer.
// Optional BTFN_PREDICT_EN: static prediction (JAL and backward branches taken). Rev 1.0
`default_nettype none

module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   input  logic        stall,
   input  logic        flush,
   input  logic [31:0] redirect_pc,
   output logic [31:0] if_id_inst,
   output logic [31:0] if_id_pc,
   output logic        if_id_valid,
   output logic        if_id_pred_taken
);

   typedef enum logic [1:0] {
      S_FETCH   = 2'd0,
      S_WAIT    = 2'd1,
      S_DISCARD = 2'd2
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic [31:0] pc;
   logic [31:0] next_pc;
   logic        pred_taken;
   logic        deliver;

   logic        buf_full;
   logic [31:0] buf_inst;
   logic [31:0] buf_pc;
   logic        buf_pred;

   // A full hold buffer blocks new requests so at most one word is ever parked.
   assign imem_req  = (state == S_FETCH) && !buf_full && !rst;
   assign imem_addr = pc & ~32'h3;
   assign deliver   = (state == S_WAIT) && imem_rvalid && !flush;

`ifdef BTFN_PREDICT_EN
   logic [31:0] jal_imm;
   logic [31:0] br_imm;
   logic        is_jal;
   logic        is_br_back;
   logic [31:0] target;

   assign jal_imm    = {{12{imem_rdata[31]}}, imem_rdata[19:12], imem_rdata[20],
                        imem_rdata[30:21], 1'b0};
   assign br_imm     = {{20{imem_rdata[31]}}, imem_rdata[7], imem_rdata[30:25],
                        imem_rdata[11:8], 1'b0};
   assign is_jal     = (imem_rdata[6:2] == 5'h1b);
   assign is_br_back = (imem_rdata[6:2] == 5'h18) && imem_rdata[31];
   assign pred_taken = is_jal || is_br_back;
   assign target     = is_jal     ? pc + jal_imm :
                       is_br_back ? pc + br_imm  :
                                    pc + 32'd4;
   assign next_pc    = target & ~32'h3;
`else
   assign pred_taken = 1'b0;
   assign next_pc    = (pc + 32'd4) & ~32'h3;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_FETCH;
      end else begin
         state <= state_nxt;
      end
   end

   // A flush with a request in flight must still swallow the returning word.
   always_comb begin
      state_nxt = state;
      case (state)
         S_FETCH: begin
            if (imem_req && imem_gnt) begin
               state_nxt = flush ? S_DISCARD : S_WAIT;
            end
         end
         S_WAIT: begin
            if (imem_rvalid) begin
               state_nxt = S_FETCH;
            end else if (flush) begin
               state_nxt = S_DISCARD;
            end
         end
         S_DISCARD: begin
            if (imem_rvalid) begin
               state_nxt = S_FETCH;
            end
         end
         default: state_nxt = S_FETCH;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc               <= RESET_PC;
         if_id_valid      <= 1'b0;
         if_id_inst       <= NOP_INST;
         if_id_pc         <= 32'h0;
         if_id_pred_taken <= 1'b0;
         buf_full         <= 1'b0;
         buf_inst         <= NOP_INST;
         buf_pc           <= 32'h0;
         buf_pred         <= 1'b0;
      end else if (flush) begin
         pc               <= redirect_pc & ~32'h3;
         if_id_valid      <= 1'b0;
         if_id_inst       <= NOP_INST;
         if_id_pred_taken <= 1'b0;
         buf_full         <= 1'b0;
      end else if (deliver) begin
         pc <= next_pc;
         if (stall) begin
            buf_full <= 1'b1;
            buf_inst <= imem_rdata;
            buf_pc   <= pc;
            buf_pred <= pred_taken;
         end else begin
            if_id_valid      <= 1'b1;
            if_id_inst       <= imem_rdata;
            if_id_pc         <= pc;
            if_id_pred_taken <= pred_taken;
         end
      end else if (!stall) begin
         if (buf_full) begin
            if_id_valid      <= 1'b1;
            if_id_inst       <= buf_inst;
            if_id_pc         <= buf_pc;
            if_id_pred_taken <= buf_pred;
            buf_full         <= 1'b0;
         end else begin
            if_id_valid      <= 1'b0;
            if_id_inst       <= NOP_INST;
            if_id_pred_taken <= 1'b0;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed vector table, reset/prediction sequences and randomized run against a queue-based model.
`default_nettype none

module tb_fetch_stage;
   localparam logic [31:0] NOP = 32'h0000_0013;

`ifdef BTFN_PREDICT_EN
   localparam logic [31:0] BEQ_NEXT = 32'h0000_0030;
   localparam logic        BEQ_PT   = 1'b1;
`else
   localparam logic [31:0] BEQ_NEXT = 32'h0000_0044;
   localparam logic        BEQ_PT   = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        stall;
   logic        flush;
   logic [31:0] redirect_pc;
   logic [31:0] if_id_inst;
   logic [31:0] if_id_pc;
   logic        if_id_valid;
   logic        if_id_pred_taken;

   int checks = 0;
   int errors = 0;

   fetch_stage dut (
      .clk(clk), .rst(rst),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .stall(stall), .flush(flush), .redirect_pc(redirect_pc),
      .if_id_inst(if_id_inst), .if_id_pc(if_id_pc),
      .if_id_valid(if_id_valid), .if_id_pred_taken(if_id_pred_taken)
   );

   always #5 clk = ~clk;

   // ---------------- checking helpers ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_outs(input string tag, input logic e_req, input logic [31:0] e_addr,
                             input logic e_valid, input logic [31:0] e_inst,
                             input logic [31:0] e_pc, input logic e_pt);
      check({tag, " req"}, {31'h0, imem_req}, {31'h0, e_req});
      if (e_req) check({tag, " addr"}, imem_addr, e_addr);
      check({tag, " valid"}, {31'h0, if_id_valid}, {31'h0, e_valid});
      check({tag, " inst"}, if_id_inst, e_inst);
      check({tag, " pc"}, if_id_pc, e_pc);
      check({tag, " pred"}, {31'h0, if_id_pred_taken}, {31'h0, e_pt});
   endtask

   task automatic drive(input logic s, input logic f, input logic g, input logic rv,
                        input logic [31:0] rd, input logic [31:0] rdr);
      stall = s; flush = f; imem_gnt = g; imem_rvalid = rv;
      imem_rdata = rd; redirect_pc = rdr;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic        stall, flush, gnt, rvalid;
      logic [31:0] rdata, redir;
      logic        e_req;
      logic [31:0] e_addr;
      logic        e_valid;
      logic [31:0] e_inst, e_pc;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic s, input logic f, input logic g, input logic rv,
                      input logic [31:0] rd, input logic [31:0] rdr,
                      input logic er, input logic [31:0] ea, input logic ev,
                      input logic [31:0] ei, input logic [31:0] ep);
      vec_t v;
      v.stall = s; v.flush = f; v.gnt = g; v.rvalid = rv; v.rdata = rd; v.redir = rdr;
      v.e_req = er; v.e_addr = ea; v.e_valid = ev; v.e_inst = ei; v.e_pc = ep;
      vecs.push_back(v);
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      logic [31:0] inst;
      logic [31:0] pc;
      logic        pt;
   } ent_t;

   ent_t        m_buf[$];
   logic [31:0] m_pc, m_gaddr, m_inst, m_ifpc;
   logic        m_busy, m_drop, m_valid, m_pt;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[26:2], 7'h13};
   endfunction

   function automatic logic [32:0] model_next(input logic [31:0] inst, input logic [31:0] pc);
      logic [31:0] off;
      logic        taken;
      taken = 1'b0;
      off   = 32'd4;
`ifdef BTFN_PREDICT_EN
      begin
         int soff;
         if (inst[6:2] == 5'h1b) begin
            soff  = $signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0});
            taken = 1'b1;
            off   = soff;
         end else if (inst[6:2] == 5'h18 && inst[31]) begin
            soff  = $signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0});
            taken = 1'b1;
            off   = soff;
         end
      end
`endif
      return {taken, (pc + off) & ~32'h3};
   endfunction

   task automatic m_reset();
      m_pc = 32'h0; m_gaddr = 32'h0; m_busy = 1'b0; m_drop = 1'b0;
      m_valid = 1'b0; m_inst = NOP; m_ifpc = 32'h0; m_pt = 1'b0;
      m_buf.delete();
   endtask

   function automatic logic m_req();
      return !m_busy && (m_buf.size() == 0);
   endfunction

   task automatic model_step(input logic s, input logic f, input logic g, input logic rv,
                             input logic [31:0] rd, input logic [31:0] rdr);
      logic        req;
      logic        delivered;
      logic [32:0] p;
      ent_t        e;
      req = m_req();
      if (f) begin
         m_valid = 1'b0; m_inst = NOP; m_pt = 1'b0;
         m_buf.delete();
         if (m_busy) begin
            m_busy = !rv;
            m_drop = !rv;
         end else if (req && g) begin
            m_busy = 1'b1; m_drop = 1'b1; m_gaddr = m_pc;
         end
         m_pc = rdr & ~32'h3;
      end else begin
         delivered = 1'b0;
         if (m_busy && rv) begin
            delivered = !m_drop;
            m_busy = 1'b0;
            m_drop = 1'b0;
         end else if (req && g) begin
            m_busy = 1'b1; m_gaddr = m_pc;
         end
         if (delivered) begin
            p = model_next(rd, m_pc);
            e.inst = rd; e.pc = m_pc; e.pt = p[32];
            m_pc = p[31:0];
            if (s) m_buf.push_back(e);
            else begin
               m_valid = 1'b1; m_inst = rd; m_ifpc = e.pc; m_pt = e.pt;
            end
         end else if (!s) begin
            if (m_buf.size() > 0) begin
               e = m_buf.pop_front();
               m_valid = 1'b1; m_inst = e.inst; m_ifpc = e.pc; m_pt = e.pt;
            end else begin
               m_valid = 1'b0; m_inst = NOP; m_pt = 1'b0;
            end
         end
      end
   endtask

   // ---------------- main test ----------------
   logic        r_s, r_f, r_g, r_rv, r_req;
   logic [31:0] r_rd, r_rdr;

   initial begin
      // stall/flush/gnt/rvalid, rdata, redirect | req, addr, valid, inst, if_id_pc
      add(0,0,1,0, 32'h0,          32'h0,    1, 32'h0,   0, NOP,          32'h0);
      add(0,0,0,1, 32'h0050_0093,  32'h0,    0, 32'h0,   0, NOP,          32'h0);
      add(0,0,1,0, 32'h0,          32'h0,    1, 32'h4,   1, 32'h0050_0093, 32'h0);
      add(0,0,0,1, 32'h0010_0113,  32'h0,    0, 32'h0,   0, NOP,          32'h0);
      add(1,0,1,0, 32'h0,          32'h0,    1, 32'h8,   1, 32'h0010_0113, 32'h4);
      add(1,0,0,1, 32'h0020_0193,  32'h0,    0, 32'h0,   1, 32'h0010_0113, 32'h4);
      add(1,0,0,0, 32'h0,          32'h0,    0, 32'h0,   1, 32'h0010_0113, 32'h4);
      add(0,0,0,0, 32'h0,          32'h0,    0, 32'h0,   1, 32'h0010_0113, 32'h4);
      add(0,0,1,0, 32'h0,          32'h0,    1, 32'hC,   1, 32'h0020_0193, 32'h8);
      add(0,1,0,0, 32'h0,          32'h103,  0, 32'h0,   0, NOP,          32'h8);
      add(0,0,0,1, 32'h0030_0213,  32'h0,    0, 32'h0,   0, NOP,          32'h8);
      add(0,0,1,0, 32'h0,          32'h0,    1, 32'h100, 0, NOP,          32'h8);
      add(1,0,0,1, 32'h0040_0293,  32'h0,    0, 32'h0,   0, NOP,          32'h8);
      add(1,1,0,0, 32'h0,          32'h200,  0, 32'h0,   0, NOP,          32'h8);
      add(0,0,1,0, 32'h0,          32'h0,    1, 32'h200, 0, NOP,          32'h8);
      add(0,0,0,0, 32'h0,          32'h0,    0, 32'h0,   0, NOP,          32'h8);
      add(0,1,0,1, 32'h0050_0313,  32'h300,  0, 32'h0,   0, NOP,          32'h8);
      add(0,0,0,0, 32'h0,          32'h0,    1, 32'h300, 0, NOP,          32'h8);
      add(0,1,1,0, 32'h0,          32'h400,  1, 32'h300, 0, NOP,          32'h8);
      add(0,0,0,1, 32'h0030_0213,  32'h0,    0, 32'h0,   0, NOP,          32'h8);
      add(0,0,1,0, 32'h0,          32'h0,    1, 32'h400, 0, NOP,          32'h8);
      add(0,0,0,1, 32'h0060_0393,  32'h0,    0, 32'h0,   0, NOP,          32'h8);
      add(1,0,1,0, 32'h0,          32'h0,    1, 32'h404, 1, 32'h0060_0393, 32'h400);

      rst = 1'b1;
      drive(0, 0, 0, 0, 32'h0, 32'h0);
      repeat (3) @(posedge clk);
      #1;
      check_outs("reset", 0, 32'h0, 0, NOP, 32'h0, 0);
      rst = 1'b0;

      foreach (vecs[i]) begin
         drive(vecs[i].stall, vecs[i].flush, vecs[i].gnt, vecs[i].rvalid,
               vecs[i].rdata, vecs[i].redir);
         #1;
         check_outs($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_addr,
                    vecs[i].e_valid, vecs[i].e_inst, vecs[i].e_pc, 1'b0);
         tick();
      end

      // Reset asserted in the middle of a WAIT cycle takes effect without a clock edge.
      drive(1, 0, 0, 0, 32'h0, 32'h0);
      #1;
      check_outs("pre_rst", 0, 32'h0, 1, 32'h0060_0393, 32'h400, 0);
      #1 rst = 1'b1;
      #1;
      check_outs("rst_async", 0, 32'h0, 0, NOP, 32'h0, 0);
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b0;
      drive(0, 0, 0, 0, 32'h0, 32'h0);
      #1;
      check_outs("post_rst", 1, 32'h0, 0, NOP, 32'h0, 0);
      tick();

      // Randomized run against the model, with redirects near the top of the address space.
      m_reset();
      for (int c = 0; c < 600; c++) begin
         r_req = m_req();
         r_s   = ($urandom_range(0, 9) < 3);
         r_f   = ($urandom_range(0, 19) == 0);
         r_g   = r_req && ($urandom_range(0, 1) == 1);
         r_rv  = m_busy && ($urandom_range(0, 1) == 1);
         r_rd  = r_rv ? mem_word(m_gaddr) : $urandom;
         r_rdr = ($urandom_range(0, 2) == 0) ? (32'hFFFF_FFE0 | 32'($urandom_range(0, 31)))
                                             : $urandom;
         drive(r_s, r_f, r_g, r_rv, r_rd, r_rdr);
         #1;
         check_outs($sformatf("rnd%0d", c), r_req, m_pc, m_valid, m_inst, m_ifpc, m_pt);
         model_step(r_s, r_f, r_g, r_rv, r_rd, r_rdr);
         tick();
      end

      // Static prediction: backward beq at 0x40, then forward bne at 0x40.
      drive(0, 0, 0, 0, 32'h0, 32'h0);
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      drive(0, 1, 0, 0, 32'h0, 32'h40);
      tick();
      drive(0, 0, 1, 0, 32'h0, 32'h0);
      #1;
      check_outs("bp_req0", 1, 32'h40, 0, NOP, 32'h0, 0);
      tick();
      drive(0, 0, 0, 1, 32'hFE00_08E3, 32'h0);
      tick();
      drive(0, 1, 0, 0, 32'h0, 32'h40);
      #1;
      check_outs("bp_beq", 1, BEQ_NEXT, 1, 32'hFE00_08E3, 32'h40, BEQ_PT);
      tick();
      drive(0, 0, 1, 0, 32'h0, 32'h0);
      #1;
      check_outs("bp_req1", 1, 32'h40, 0, NOP, 32'h40, 0);
      tick();
      drive(0, 0, 0, 1, 32'h0000_1463, 32'h0);
      tick();
      drive(0, 0, 0, 0, 32'h0, 32'h0);
      #1;
      check_outs("bp_bne", 1, 32'h44, 1, 32'h0000_1463, 32'h40, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire
